// File: rtl/writeback_ctrl.sv
// writeback_ctrl: arbitrates load returns and ALU results into one register-file write per cycle and drives PC update.
module writeback_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [3:0]  alu_dest,
    input  logic [31:0] alu_result,
    output logic        alu_ready,
    input  logic        ld_issue,
    input  logic [3:0]  ld_dest,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        mem_rready,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        pc_hold,
    input  logic [31:0] pc_in,
    output logic        write_en,
    output logic [3:0]  write_dest,
    output logic [31:0] write_in,
    output logic [31:0] next_pc,
    output logic        pc_en,
    output logic [15:0] busy_mask,
    output logic        ld_full,
    output logic        wb_err
);
    logic [3:0]  r_fifo [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        r_skid_v;
    logic [3:0]  r_skid_dest;
    logic [31:0] r_skid_data;
    logic [15:0] r_busy;
    logic        r_err;
    logic        r_wen;
    logic [3:0]  r_wdest;
    logic [31:0] r_wdata;
    logic        w_pop;
    logic        w_push;
    logic        w_tail;
    logic        w_alu_acc;
    logic        w_sel_v;
    logic [3:0]  w_sel_dest;
    logic [31:0] w_sel_data;
    logic        w_dest_ok;
    logic        w_err;
    logic [15:0] w_clr;
    logic [15:0] w_set;

    assign w_pop      = mem_rvalid & (r_count != 2'd0);
    assign w_push     = ld_issue & ((r_count != 2'd2) | w_pop);
    assign w_tail     = r_head ^ r_count[0];
    assign w_alu_acc  = alu_valid & ~r_skid_v;
    assign w_sel_v    = w_pop | r_skid_v | w_alu_acc;
    assign w_sel_dest = w_pop ? r_fifo[r_head] : r_skid_v ? r_skid_dest : alu_dest;
    assign w_sel_data = w_pop ? mem_rdata : r_skid_v ? r_skid_data : alu_result;
    assign w_dest_ok  = w_sel_dest <= 4'b1010;
    assign w_err      = (ld_issue & ~w_push) | (mem_rvalid & (r_count == 2'd0)) | (w_sel_v & ~w_dest_ok);
    // a same-cycle issue to the retiring destination keeps its busy bit set
    assign w_clr      = w_pop ? (16'd1 << r_fifo[r_head]) : 16'd0;
    assign w_set      = w_push ? (16'd1 << ld_dest) : 16'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_head      <= 1'b0;
            r_count     <= 2'd0;
            r_skid_v    <= 1'b0;
            r_skid_dest <= '0;
            r_skid_data <= '0;
            r_busy      <= '0;
            r_err       <= 1'b0;
            r_wen       <= 1'b0;
            r_wdest     <= '0;
            r_wdata     <= '0;
        end else begin
            if (w_push)
                r_fifo[w_tail] <= ld_dest;
            r_head  <= r_head ^ w_pop;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            r_skid_v <= w_pop & (r_skid_v | w_alu_acc);
            if (w_pop & w_alu_acc) begin
                r_skid_dest <= alu_dest;
                r_skid_data <= alu_result;
            end
            r_busy <= (r_busy & ~w_clr) | w_set;
            r_err  <= r_err | w_err;
            r_wen  <= w_sel_v & w_dest_ok;
            if (w_sel_v) begin
                r_wdest <= w_sel_dest;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign alu_ready  = ~r_skid_v;
    assign mem_rready = r_count != 2'd0;
    assign ld_full    = r_count == 2'd2;
    assign busy_mask  = r_busy;
    assign wb_err     = r_err;
    assign write_en   = r_wen;
    assign write_dest = r_wdest;
    assign write_in   = r_wdata;
    assign next_pc    = branch_valid ? branch_target : pc_in + 32'd4;
    assign pc_en      = ~pc_hold & ~(r_wen & (r_wdest == 4'b1001));
endmodule

// File: tb/tb_writeback_ctrl.sv
// tb_writeback_ctrl: directed stimulus with a write scoreboard checked by an independent monitor.
module tb_writeback_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [3:0]  alu_dest;
    logic [31:0] alu_result;
    logic        alu_ready;
    logic        ld_issue;
    logic [3:0]  ld_dest;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rready;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        pc_hold;
    logic [31:0] pc_in;
    logic        write_en;
    logic [3:0]  write_dest;
    logic [31:0] write_in;
    logic [31:0] next_pc;
    logic        pc_en;
    logic [15:0] busy_mask;
    logic        ld_full;
    logic        wb_err;
    logic [35:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    writeback_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_result(alu_result), .alu_ready(alu_ready),
        .ld_issue(ld_issue), .ld_dest(ld_dest),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .pc_hold(pc_hold), .pc_in(pc_in),
        .write_en(write_en), .write_dest(write_dest), .write_in(write_in),
        .next_pc(next_pc), .pc_en(pc_en),
        .busy_mask(busy_mask), .ld_full(ld_full), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && write_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got dest %h data %h expected no write", write_dest, write_in);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({write_dest, write_in} !== e) begin
                    errors++;
                    $display("FAIL write: got dest %h data %h expected dest %h data %h", write_dest, write_in, e[35:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; alu_valid = 1'b0; alu_dest = '0; alu_result = '0;
        ld_issue = 1'b0; ld_dest = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        branch_valid = 1'b0; branch_target = '0; pc_hold = 1'b0; pc_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_write_en", {31'd0, write_en}, 32'd0);
        chk("rst_write_dest", {28'd0, write_dest}, 32'd0);
        chk("rst_write_in", write_in, 32'd0);
        chk("rst_busy", {16'd0, busy_mask}, 32'd0);
        chk("rst_ld_full", {31'd0, ld_full}, 32'd0);
        chk("rst_mem_rready", {31'd0, mem_rready}, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
        cyc(); rst_n = 1'b1;
        cyc();
        // single ALU write lands one cycle after acceptance
        alu_valid = 1'b1; alu_dest = 4'd2; alu_result = 32'hdeadbeef;
        exp_q.push_back({4'd2, 32'hdeadbeef});
        cyc(); alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_latency", {31'd0, write_en}, 32'd1);
        cyc();
        // load return collides with an ALU result; the ALU result goes through the skid buffer
        ld_issue = 1'b1; ld_dest = 4'd1;
        cyc(); ld_issue = 1'b0;
        @(negedge clk);
        chk("busy_r1", {16'd0, busy_mask}, 32'h2);
        chk("rready_r1", {31'd0, mem_rready}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h11;
        alu_valid = 1'b1; alu_dest = 4'd3; alu_result = 32'h22;
        exp_q.push_back({4'd1, 32'h11});
        exp_q.push_back({4'd3, 32'h22});
        cyc(); mem_rvalid = 1'b0; alu_valid = 1'b0;
        @(negedge clk);
        chk("collide_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("collide_busy_clr", {16'd0, busy_mask}, 32'h0);
        chk("collide_dest", {28'd0, write_dest}, 32'd1);
        cyc();
        @(negedge clk);
        chk("skid_drain_dest", {28'd0, write_dest}, 32'd3);
        chk("skid_alu_ready", {31'd0, alu_ready}, 32'd1);
        cyc();
        // FIFO full: third issue is dropped and flags an error
        ld_issue = 1'b1; ld_dest = 4'd4;
        cyc(); ld_dest = 4'd5;
        cyc(); ld_issue = 1'b0;
        @(negedge clk);
        chk("fifo_full", {31'd0, ld_full}, 32'd1);
        chk("busy_r4r5", {16'd0, busy_mask}, 32'h30);
        chk("no_err_yet", {31'd0, wb_err}, 32'd0);
        ld_issue = 1'b1; ld_dest = 4'd6;
        cyc(); ld_issue = 1'b0;
        @(negedge clk);
        chk("overflow_err", {31'd0, wb_err}, 32'd1);
        chk("overflow_busy", {16'd0, busy_mask}, 32'h30);
        mem_rvalid = 1'b1; mem_rdata = 32'h44;
        exp_q.push_back({4'd4, 32'h44});
        cyc(); mem_rdata = 32'h55;
        exp_q.push_back({4'd5, 32'h55});
        cyc(); mem_rvalid = 1'b0;
        @(negedge clk);
        chk("drained_full", {31'd0, ld_full}, 32'd0);
        chk("drained_rready", {31'd0, mem_rready}, 32'd0);
        chk("drained_busy", {16'd0, busy_mask}, 32'h0);
        cyc();
        // PC generation
        pc_in = 32'hfffffffc;
        #1;
        chk("pc_wrap", next_pc, 32'h0);
        chk("pc_en_idle", {31'd0, pc_en}, 32'd1);
        branch_valid = 1'b1; branch_target = 32'h40;
        #1;
        chk("pc_branch", next_pc, 32'h40);
        pc_hold = 1'b1;
        #1;
        chk("pc_hold", {31'd0, pc_en}, 32'd0);
        branch_valid = 1'b0; pc_hold = 1'b0;
        // register write to PC suppresses sequential PC update
        alu_valid = 1'b1; alu_dest = 4'd9; alu_result = 32'heeeeffff;
        exp_q.push_back({4'd9, 32'heeeeffff});
        cyc(); alu_valid = 1'b0;
        @(negedge clk);
        chk("pc_write_en", {31'd0, write_en}, 32'd1);
        chk("pc_write_pc_en", {31'd0, pc_en}, 32'd0);
        cyc();
        // IMM destinations are dropped; a dropped load still pops
        alu_valid = 1'b1; alu_dest = 4'hf; alu_result = 32'h99;
        cyc(); alu_valid = 1'b0;
        @(negedge clk);
        chk("imm_alu_dropped", {31'd0, write_en}, 32'd0);
        ld_issue = 1'b1; ld_dest = 4'hf;
        cyc(); ld_issue = 1'b0;
        @(negedge clk);
        chk("imm_busy", {16'd0, busy_mask}, 32'h8000);
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        cyc(); mem_rvalid = 1'b0;
        @(negedge clk);
        chk("imm_ld_dropped", {31'd0, write_en}, 32'd0);
        chk("imm_ld_popped", {31'd0, mem_rready}, 32'd0);
        chk("imm_busy_clr", {16'd0, busy_mask}, 32'h0);
        chk("err_sticky", {31'd0, wb_err}, 32'd1);
        cyc();
        // reset mid-load discards the pending entry
        ld_issue = 1'b1; ld_dest = 4'd7;
        cyc(); ld_issue = 1'b0;
        @(negedge clk);
        chk("busy_r7", {16'd0, busy_mask}, 32'h80);
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {16'd0, busy_mask}, 32'h0);
        chk("midrst_rready", {31'd0, mem_rready}, 32'd0);
        chk("midrst_err", {31'd0, wb_err}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        cyc(); mem_rvalid = 1'b0;
        @(negedge clk);
        chk("stray_rvalid_err", {31'd0, wb_err}, 32'd1);
        chk("stray_rvalid_nowrite", {31'd0, write_en}, 32'd0);
        repeat (3) cyc();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
